pcie_x1_lsm: RTL and testbench
==============================

Name: pcie_x1_lsm

Overview:
Receive lane synchronisation state machine for the x1 PCIe link, running in the recovered-clock domain (clk_in).
- Takes decoded 8b10b symbols plus code-violation and disparity flags from the PCS.
- Acquires and monitors symbol lock using COM (K28.5, 0xBC) characters.
- Produces the registered data/kcntl/status/lanesync stream that feeds the clock-tolerance compensation FIFO stage directly.

Parameters:
COMMA_CNT, 4, number of error-free COMs needed to declare sync (legal 2..15)
GOOD_CNT, 16, consecutive valid symbols that forgive one error while in sync (legal 2..255)
ERR_MAX, 4, accumulated errors that drop sync (legal 1..15)

Ports:
clk_in  input  1  recovered receive symbol clock
rst_n  input  1  asynchronous active-low reset
rx_data_in  input  8  decoded symbol
rx_kcntl_in  input  1  symbol is a K character
rx_cv_in  input  1  8b10b code violation on this symbol
rx_disp_err_in  input  1  running-disparity error on this symbol
rx_los_in  input  1  loss of signal (level, already in clk_in domain)
data_out  output  8  registered symbol to CTC
kcntl_out  output  1  registered K flag
status_out  output  3  PIPE-style RxStatus
lanesync_out  output  1  lane in sync
sync_lost  output  1  one-cycle pulse on SYNC->LOS transition
lsm_state  output  2  debug: 00 LOS, 01 ACQ, 10 SYNC

Behaviour:
Reset and clocking
- Reset: state LOS; all counters 0; all outputs 0, including status_out=000.
- Reset is asynchronous and may occur mid-operation. On release, resume from LOS. Outputs must not glitch high.

Symbol classification (per cycle)
- invalid = rx_cv_in | rx_disp_err_in.
- comma = rx_kcntl_in & (rx_data_in==8'hBC) & ~invalid.
- An invalid COM counts as invalid, never as a comma.

Output timing and data
- Latency: exactly 1 clk_in cycle for all outputs.
- lanesync_out, lsm_state and sync_lost at cycle n+1 reflect the state after processing the symbol presented at cycle n.
- data_out/kcntl_out = input symbol delayed 1 cycle.
- Exception: when rx_cv_in=1, data_out=8'hFE and kcntl_out=1 (EDB substitution).

status_out encoding
- rx_cv_in=1: 100 (decode error).
- Else rx_disp_err_in=1: 111 (disparity error).
- Else: 000.

Counters
- comma_cnt: 4 bits.
- err_cnt: 4 bits.
- good_cnt: 8 bits.
- No counter wraps. err_cnt decrement saturates at 0.

State machine
- rx_los_in=1 has top priority in every state:
  - next state LOS; all counters cleared.
  - sync_lost pulses if the current state is SYNC.
- LOS:
  - comma -> ACQ, comma_cnt=1.
  - Anything else -> stay, comma_cnt=0.
- ACQ:
  - invalid -> LOS, comma_cnt=0. This applies even if the symbol would have been the final COM.
  - comma with comma_cnt+1==COMMA_CNT -> SYNC; err_cnt=0, good_cnt=0, comma_cnt=0.
  - comma otherwise -> comma_cnt+1.
  - Valid non-comma -> stay, count unchanged. Data between COMs is allowed.
- SYNC (lanesync_out=1):
  - invalid -> good_cnt=0, err_cnt+1.
    - If err_cnt+1==ERR_MAX: next state LOS, sync_lost=1 for one cycle, counters cleared.
  - valid with good_cnt+1==GOOD_CNT -> good_cnt=0, err_cnt=max(err_cnt-1,0).
  - valid otherwise -> good_cnt+1.
- sync_lost is 0 in all other cycles.
- No other transitions exist. lsm_state value 11 is unreachable; if entered, the next state is LOS.
- The symbol that causes entry to SYNC is output with lanesync_out=1. The symbol that causes loss is output with lanesync_out=0.

Test Plan:
1. Reset, then COM,D,D,COM,COM,D,COM (all valid) -> lanesync_out rises 1 cycle after 4th COM; lsm_state 00->01->10; data_out matches input delayed 1.
2. In ACQ after 2 COMs, assert rx_cv_in with data 0x55 -> state LOS. That cycle+1: data_out=0xFE, kcntl_out=1, status_out=100. A further 4 COMs are then required to reach sync.
3. In SYNC, 4 disparity errors spaced 5 symbols apart -> status_out=111 on each. lanesync_out falls and sync_lost pulses high for exactly 1 cycle, 1 cycle after the 4th error.
4. In SYNC: 1 error, 16 valid symbols, then 3 errors -> err_cnt goes 1->0->3; lanesync_out stays 1. One more error -> sync lost.
5. Assert rx_los_in for 1 cycle mid-SYNC, simultaneously with a valid COM -> LOS wins; sync_lost pulses; lanesync_out=0 next cycle. Asserting rx_los_in again while already in LOS gives no pulse.
6. Assert rst_n low mid-SYNC (asynchronous, between edges) -> all outputs 0 immediately. After release, COMMA_CNT COMs are needed before lanesync_out=1.

Source files
------------

// File: rtl/pcie_x1_lsm.sv
// pcie_x1_lsm: receive lane synchronisation state machine for the x1 link.
// Acquires symbol lock on error-free COM characters and monitors it with an
// error budget that is paid back by runs of good symbols. All outputs are
// registered, one clk_in cycle after the symbol they describe.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOS   | no lock; waiting for the first clean COM
// ACQ   | counting clean COMs towards lock; any bad symbol gives up
// SYNC  | locked; errors accumulate, GOOD_CNT clean symbols forgive one
module pcie_x1_lsm #(
  parameter int COMMA_CNT = 4,
  parameter int GOOD_CNT  = 16,
  parameter int ERR_MAX   = 4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [7:0] rx_data_in,
  input  logic       rx_kcntl_in,
  input  logic       rx_cv_in,
  input  logic       rx_disp_err_in,
  input  logic       rx_los_in,
  output logic [7:0] data_out,
  output logic       kcntl_out,
  output logic [2:0] status_out,
  output logic       lanesync_out,
  output logic       sync_lost,
  output logic [1:0] lsm_state
);

  localparam logic [1:0] ST_LOS  = 2'b00;
  localparam logic [1:0] ST_ACQ  = 2'b01;
  localparam logic [1:0] ST_SYNC = 2'b10;

  localparam logic [3:0] COMMA_TGT = 4'(COMMA_CNT);
  localparam logic [7:0] GOOD_TGT  = 8'(GOOD_CNT);
  localparam logic [3:0] ERR_TGT   = 4'(ERR_MAX);

  logic [1:0] state_q, state_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [7:0] good_cnt_q, good_cnt_d;

  logic       invalid, comma;
  logic [7:0] data_d;
  logic       kcntl_d;
  logic [2:0] status_d;
  logic       lanesync_d, sync_lost_d;

  assign invalid = rx_cv_in | rx_disp_err_in;
  assign comma   = rx_kcntl_in & (rx_data_in == 8'hBC) & ~invalid;

  // State and counter registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOS;
      comma_cnt_q <= 4'd0;
      err_cnt_q   <= 4'd0;
      good_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

  // Next-state and counter update; loss of signal overrides everything
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    if (rx_los_in) begin
      state_d     = ST_LOS;
      comma_cnt_d = 4'd0;
      err_cnt_d   = 4'd0;
      good_cnt_d  = 8'd0;
    end else begin
      case (state_q)
        ST_LOS: begin
          err_cnt_d  = 4'd0;
          good_cnt_d = 8'd0;
          if (comma) begin
            state_d     = ST_ACQ;
            comma_cnt_d = 4'd1;
          end else begin
            comma_cnt_d = 4'd0;
          end
        end
        ST_ACQ: begin
          if (invalid) begin
            state_d     = ST_LOS;
            comma_cnt_d = 4'd0;
          end else if (comma) begin
            if (comma_cnt_q + 4'd1 == COMMA_TGT) begin
              state_d     = ST_SYNC;
              comma_cnt_d = 4'd0;
              err_cnt_d   = 4'd0;
              good_cnt_d  = 8'd0;
            end else begin
              comma_cnt_d = comma_cnt_q + 4'd1;
            end
          end
        end
        ST_SYNC: begin
          if (invalid) begin
            good_cnt_d = 8'd0;
            if (err_cnt_q + 4'd1 == ERR_TGT) begin
              state_d     = ST_LOS;
              comma_cnt_d = 4'd0;
              err_cnt_d   = 4'd0;
            end else begin
              err_cnt_d = err_cnt_q + 4'd1;
            end
          end else if (good_cnt_q + 8'd1 == GOOD_TGT) begin
            good_cnt_d = 8'd0;
            err_cnt_d  = (err_cnt_q == 4'd0) ? 4'd0 : err_cnt_q - 4'd1;
          end else begin
            good_cnt_d = good_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d     = ST_LOS;
          comma_cnt_d = 4'd0;
          err_cnt_d   = 4'd0;
          good_cnt_d  = 8'd0;
        end
      endcase
    end
  end

  // Output values for the current symbol, with EDB substitution on code violations
  always_comb begin
    data_d      = rx_cv_in ? 8'hFE : rx_data_in;
    kcntl_d     = rx_cv_in | rx_kcntl_in;
    status_d    = rx_cv_in ? 3'b100 : (rx_disp_err_in ? 3'b111 : 3'b000);
    lanesync_d  = (state_d == ST_SYNC);
    sync_lost_d = (state_q == ST_SYNC) && (state_d == ST_LOS);
  end

  // Output registers, cleared asynchronously so nothing glitches high in reset
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= 8'd0;
      kcntl_out    <= 1'b0;
      status_out   <= 3'b000;
      lanesync_out <= 1'b0;
      sync_lost    <= 1'b0;
    end else begin
      data_out     <= data_d;
      kcntl_out    <= kcntl_d;
      status_out   <= status_d;
      lanesync_out <= lanesync_d;
      sync_lost    <= sync_lost_d;
    end
  end

  assign lsm_state = state_q;

endmodule

// File: tb/tb_pcie_x1_lsm.sv
// Testbench for pcie_x1_lsm: directed scenarios plus randomized symbol
// streams, every cycle compared against a rule-level reference model.
module tb_pcie_x1_lsm;

  localparam int COMMA_CNT = 4;
  localparam int GOOD_CNT  = 16;
  localparam int ERR_MAX   = 4;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] rx_data_in = 8'd0;
  logic       rx_kcntl_in = 1'b0;
  logic       rx_cv_in = 1'b0;
  logic       rx_disp_err_in = 1'b0;
  logic       rx_los_in = 1'b0;
  logic [7:0] data_out;
  logic       kcntl_out;
  logic [2:0] status_out;
  logic       lanesync_out;
  logic       sync_lost;
  logic [1:0] lsm_state;

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = no lock, 1 = acquiring, 2 = locked
  int m_mode = 0;
  int m_commas = 0;
  int m_errs = 0;
  int m_good = 0;
  logic [7:0] e_data = 8'd0;
  logic       e_k = 1'b0;
  logic [2:0] e_status = 3'd0;
  logic       e_sync = 1'b0;
  logic       e_lost = 1'b0;
  logic [1:0] e_state = 2'd0;

  pcie_x1_lsm #(.COMMA_CNT(COMMA_CNT), .GOOD_CNT(GOOD_CNT), .ERR_MAX(ERR_MAX)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .rx_data_in(rx_data_in), .rx_kcntl_in(rx_kcntl_in), .rx_cv_in(rx_cv_in),
    .rx_disp_err_in(rx_disp_err_in), .rx_los_in(rx_los_in),
    .data_out(data_out), .kcntl_out(kcntl_out), .status_out(status_out),
    .lanesync_out(lanesync_out), .sync_lost(sync_lost), .lsm_state(lsm_state)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_commas = 0; m_errs = 0; m_good = 0;
    e_data = 8'd0; e_k = 1'b0; e_status = 3'd0;
    e_sync = 1'b0; e_lost = 1'b0; e_state = 2'd0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic k, input logic cv,
                            input logic de, input logic los);
    bit bad;
    bit com;
    int prev;
    bad  = cv || de;
    com  = k && (d == 8'hBC) && !bad;
    prev = m_mode;
    if (los) begin
      m_mode = 0; m_commas = 0; m_errs = 0; m_good = 0;
    end else if (m_mode == 0) begin
      if (com) begin m_mode = 1; m_commas = 1; end
      else m_commas = 0;
    end else if (m_mode == 1) begin
      if (bad) begin
        m_mode = 0; m_commas = 0;
      end else if (com) begin
        m_commas++;
        if (m_commas == COMMA_CNT) begin
          m_mode = 2; m_commas = 0; m_errs = 0; m_good = 0;
        end
      end
    end else begin
      if (bad) begin
        m_good = 0;
        m_errs++;
        if (m_errs == ERR_MAX) begin
          m_mode = 0; m_errs = 0; m_commas = 0;
        end
      end else begin
        m_good++;
        if (m_good == GOOD_CNT) begin
          m_good = 0;
          if (m_errs > 0) m_errs--;
        end
      end
    end
    e_lost   = (prev == 2) && (m_mode == 0);
    e_sync   = (m_mode == 2);
    e_state  = 2'(m_mode);
    e_data   = cv ? 8'hFE : d;
    e_k      = cv ? 1'b1 : k;
    e_status = cv ? 3'b100 : (de ? 3'b111 : 3'b000);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".data"}, 32'(data_out), 32'(e_data));
    check_eq({tag, ".kcntl"}, 32'(kcntl_out), 32'(e_k));
    check_eq({tag, ".status"}, 32'(status_out), 32'(e_status));
    check_eq({tag, ".lanesync"}, 32'(lanesync_out), 32'(e_sync));
    check_eq({tag, ".sync_lost"}, 32'(sync_lost), 32'(e_lost));
    check_eq({tag, ".state"}, 32'(lsm_state), 32'(e_state));
  endtask

  task automatic step(input logic [7:0] d, input logic k, input logic cv,
                      input logic de, input logic los);
    @(negedge clk_in);
    rx_data_in = d; rx_kcntl_in = k; rx_cv_in = cv; rx_disp_err_in = de; rx_los_in = los;
    model_step(d, k, cv, de, los);
    @(posedge clk_in);
    #1;
    compare_all("cyc");
  endtask

  task automatic com();
    step(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic dat(input logic [7:0] d);
    step(d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic get_sync();
    repeat (COMMA_CNT) com();
    check_eq("get_sync", 32'(lanesync_out), 32'd1);
  endtask

  // Asynchronous reset between edges; outputs must clear immediately
  task automatic do_reset();
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_now");
    rx_data_in = 8'd0; rx_kcntl_in = 1'b0; rx_cv_in = 1'b0;
    rx_disp_err_in = 1'b0; rx_los_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    compare_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    int err_pct;
    int r;
    logic [7:0] d;
    logic k;

    #12;
    model_reset();
    compare_all("reset");
    rst_n = 1'b1;

    // Plan 1: lock after the fourth clean COM with data in between
    com(); check_eq("p1.acq", 32'(lsm_state), 32'd1);
    dat(8'h11); dat(8'h22); com(); com(); dat(8'h33);
    check_eq("p1.not_yet", 32'(lanesync_out), 32'd0);
    com();
    check_eq("p1.lock", 32'(lanesync_out), 32'd1);
    check_eq("p1.state", 32'(lsm_state), 32'd2);

    // Plan 2: code violation during acquisition
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    com(); com();
    step(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("p2.edb", 32'(data_out), 32'hFE);
    check_eq("p2.k", 32'(kcntl_out), 32'd1);
    check_eq("p2.status", 32'(status_out), 32'd4);
    check_eq("p2.los", 32'(lsm_state), 32'd0);
    repeat (COMMA_CNT - 1) com();
    check_eq("p2.still_acq", 32'(lanesync_out), 32'd0);
    com();
    check_eq("p2.relock", 32'(lanesync_out), 32'd1);

    // Plan 3: four disparity errors five symbols apart
    for (int i = 0; i < ERR_MAX; i++) begin
      step(8'h4A, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("p3.status", 32'(status_out), 32'd7);
      if (i < ERR_MAX - 1) repeat (4) dat(8'h5A);
    end
    check_eq("p3.lost", 32'(sync_lost), 32'd1);
    check_eq("p3.sync", 32'(lanesync_out), 32'd0);
    dat(8'h00);
    check_eq("p3.pulse_end", 32'(sync_lost), 32'd0);

    // Plan 4: one error forgiven, then three more survive, a fourth drops lock
    get_sync();
    step(8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (GOOD_CNT) dat(8'h20);
    repeat (3) step(8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("p4.held", 32'(lanesync_out), 32'd1);
    step(8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("p4.lost", 32'(sync_lost), 32'd1);

    // Plan 5: loss of signal beats a valid COM; no pulse when already in LOS
    get_sync();
    step(8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("p5.pulse", 32'(sync_lost), 32'd1);
    check_eq("p5.sync", 32'(lanesync_out), 32'd0);
    step(8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("p5.no_pulse", 32'(sync_lost), 32'd0);

    // Plan 6: asynchronous reset mid-lock, then full reacquisition
    get_sync();
    dat(8'h77);
    do_reset();
    repeat (COMMA_CNT - 1) com();
    check_eq("p6.wait", 32'(lanesync_out), 32'd0);
    com();
    check_eq("p6.lock", 32'(lanesync_out), 32'd1);

    // Randomized streams at several error rates, with occasional resets
    for (int phase = 0; phase < 3; phase++) begin
      err_pct = (phase == 0) ? 2 : ((phase == 1) ? 6 : 14);
      for (int n = 0; n < 1500; n++) begin
        if ((n % 500) == 499) do_reset();
        r = $urandom_range(0, 999);
        d = 8'($urandom);
        k = ($urandom_range(0, 9) == 0);
        if (r < 3)
          step(d, k, 1'b0, 1'b0, 1'b1);
        else if (r < 3 + err_pct * 5)
          step(($urandom_range(0, 1) == 1) ? 8'hBC : d, 1'b1, 1'b1, 1'b0, 1'b0);
        else if (r < 3 + err_pct * 10)
          step(($urandom_range(0, 1) == 1) ? 8'hBC : d, k, 1'b0, 1'b1, 1'b0);
        else if (r < 500)
          com();
        else if (r < 520)
          step(8'hBC, 1'b0, 1'b0, 1'b0, 1'b0);
        else
          step(d, k, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
